// File: rtl/extensor_pkg.sv
// ---------------------------------------------------------------------------
// extensor_pkg
// Shared types, constants and the extension function of the immediate
// extension pipeline.
//   modo_ext_t    : the eight extension-mode encodings
//   PROFUNDIDADE  : number of entries in the output skid buffer
//   EXT_MAX_W     : widest datapath the extension function handles
//   estender()    : pure combinational extension, returns {erro, saida}
// Optional build macro: EXTENSOR_BYTE_MEIA_EN enables the 1xx load-extension
// modes (byte / half-word); without it every 1xx mode is reported as illegal.
// ---------------------------------------------------------------------------
package extensor_pkg;

    localparam int PROFUNDIDADE = 2;
    localparam int EXT_MAX_W    = 64;

    typedef enum logic [2:0] {
        MODO_SINAL      = 3'b000,
        MODO_ZERO       = 3'b001,
        MODO_SUPERIOR   = 3'b010,
        MODO_DESVIO     = 3'b011,
        MODO_SINAL_BYTE = 3'b100,
        MODO_ZERO_BYTE  = 3'b101,
        MODO_SINAL_MEIA = 3'b110,
        MODO_ZERO_MEIA  = 3'b111
    } modo_ext_t;

    // Keep only the low 'largura' bits of 'valor'.
    function automatic logic [EXT_MAX_W-1:0] ext_zero(
        input logic [EXT_MAX_W-1:0] valor,
        input int                   largura
    );
        logic [EXT_MAX_W-1:0] mascara;
        mascara = (64'd1 << largura) - 64'd1;
        return valor & mascara;
    endfunction

    // Sign-extend the low 'largura' bits of 'valor' to EXT_MAX_W bits.
    function automatic logic [EXT_MAX_W-1:0] ext_sinal(
        input logic [EXT_MAX_W-1:0] valor,
        input int                   largura
    );
        logic [EXT_MAX_W-1:0] mascara;
        logic [EXT_MAX_W-1:0] res;
        mascara = (64'd1 << largura) - 64'd1;
        if (valor[largura-1]) begin
            res = valor | ~mascara;
        end else begin
            res = valor & mascara;
        end
        return res;
    endfunction

    // Extend an in_w-bit immediate (zero-padded into EXT_MAX_W bits) to
    // out_w bits. Result bit EXT_MAX_W is the illegal-mode flag; bits above
    // out_w-1 of the value part are always zero.
    function automatic logic [EXT_MAX_W:0] estender(
        input logic [EXT_MAX_W-1:0] entrada,
        input modo_ext_t            modo,
        input int                   in_w,
        input int                   out_w
    );
        logic [EXT_MAX_W-1:0] mascara_out;
        logic [EXT_MAX_W-1:0] resultado;
        logic                 erro;
        mascara_out = (64'd1 << out_w) - 64'd1;
        resultado   = {EXT_MAX_W{1'b0}};
        erro        = 1'b0;
        case (modo)
            MODO_SINAL:    resultado = ext_sinal(entrada, in_w);
            MODO_ZERO:     resultado = ext_zero(entrada, in_w);
            MODO_SUPERIOR: resultado = ext_zero(entrada, in_w) << (out_w - in_w);
            // Bits pushed above out_w-1 by the shift are removed by the mask below.
            MODO_DESVIO:   resultado = ext_sinal(entrada, in_w) << 2;
`ifdef EXTENSOR_BYTE_MEIA_EN
            MODO_SINAL_BYTE: resultado = ext_sinal(entrada, 8);
            MODO_ZERO_BYTE:  resultado = ext_zero(entrada, 8);
            MODO_SINAL_MEIA: resultado = ext_sinal(entrada, 16);
            MODO_ZERO_MEIA:  resultado = ext_zero(entrada, 16);
`endif
            default: begin
                resultado = {EXT_MAX_W{1'b0}};
                erro      = 1'b1;
            end
        endcase
        return {erro, resultado & mascara_out};
    endfunction

endpackage

// File: rtl/skid_buffer_2.sv
// ---------------------------------------------------------------------------
// skid_buffer_2
// Generic two-entry valid/ready FIFO. Data pushed in cycle N is visible at
// the output in cycle N+1; there is no input-to-output bypass.
//   clk, rst_n          : clock, asynchronous active-low reset
//   srst                : synchronous flush (drops all entries)
//   in_data/in_valid    : producer side, in_ready is a registered flag
//   out_data/out_valid  : head entry (zero while empty), out_ready pops it
// in_ready never depends combinationally on out_ready: a full buffer refuses
// the push even in a cycle where it is also being popped.
// ---------------------------------------------------------------------------
module skid_buffer_2
    import extensor_pkg::*;
#(
    parameter int W = 38
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         srst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] mem_r [0:PROFUNDIDADE-1];
    logic         wr_ptr_r;
    logic         rd_ptr_r;
    logic [1:0]   count_r;
    logic [1:0]   count_next_s;
    logic         in_ready_r;
    logic         push_s;
    logic         pop_s;
    logic         out_valid_s;

    assign out_valid_s = (count_r != 2'd0);
    assign push_s      = in_valid && in_ready_r;
    assign pop_s       = out_valid_s && out_ready;

    // Occupancy update: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Storage, circular pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PROFUNDIDADE; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
            wr_ptr_r   <= 1'b0;
            rd_ptr_r   <= 1'b0;
            count_r    <= 2'd0;
            in_ready_r <= 1'b0;
        end else if (srst) begin
            for (int i = 0; i < PROFUNDIDADE; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
            wr_ptr_r   <= 1'b0;
            rd_ptr_r   <= 1'b0;
            count_r    <= 2'd0;
            in_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= in_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r    <= count_next_s;
            in_ready_r <= (count_next_s < 2'(PROFUNDIDADE));
        end
    end

    // Present the head entry; an empty buffer shows all zeros.
    always_comb begin
        if (out_valid_s) begin
            out_data = mem_r[rd_ptr_r];
        end else begin
            out_data = {W{1'b0}};
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_s;

endmodule

// File: rtl/extensor_imediato_pipe.sv
// ---------------------------------------------------------------------------
// extensor_imediato_pipe
// Registered immediate-extension unit between decode and the ALU operand mux.
// The immediate is extended combinationally at push time and the result
// (with its tag and illegal-mode flag) is queued in a 2-entry skid buffer.
//   clk, reset_n                  : clock, asynchronous active-low reset
//   entrada, modo, tag_in         : immediate, extension mode, sideband tag
//   in_valid / in_ready           : producer handshake
//   saida, tag_out, erro          : head result, its tag, illegal-mode flag
//   out_valid / out_ready         : consumer handshake
// Parameters: IN_W (8..OUT_W-2), OUT_W (< 64), TAG_W.
// Optional build macro: EXTENSOR_BYTE_MEIA_EN adds the byte/half-word modes.
// ---------------------------------------------------------------------------
module extensor_imediato_pipe
    import extensor_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IN_W-1:0]  entrada,
    input  logic [2:0]       modo,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] saida,
    output logic [TAG_W-1:0] tag_out,
    output logic             erro,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CARGA_W = OUT_W + TAG_W + 1;

    logic [EXT_MAX_W:0]   ext_s;
    logic [OUT_W-1:0]     saida_ext_s;
    logic                 erro_ext_s;
    logic                 unused_ext_s;
    logic [CARGA_W-1:0]   carga_in_s;
    logic [CARGA_W-1:0]   carga_out_s;

    // Extension of the incoming immediate; the stored item is the result,
    // never the raw input. Value bits above OUT_W are zero by construction.
    always_comb begin
        ext_s        = estender(EXT_MAX_W'(entrada), modo_ext_t'(modo), IN_W, OUT_W);
        saida_ext_s  = ext_s[OUT_W-1:0];
        erro_ext_s   = ext_s[EXT_MAX_W];
        unused_ext_s = ^ext_s[EXT_MAX_W-1:OUT_W];
        carga_in_s   = {erro_ext_s, tag_in, saida_ext_s};
    end

    skid_buffer_2 #(
        .W (CARGA_W)
    ) u_buffer (
        .clk       (clk),
        .rst_n     (reset_n),
        .srst      (1'b0),
        .in_data   (carga_in_s),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (carga_out_s),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign saida   = carga_out_s[OUT_W-1:0];
    assign tag_out = carga_out_s[OUT_W+TAG_W-1:OUT_W];
    assign erro    = carga_out_s[CARGA_W-1];

endmodule
